// File: rtl/oc8051_ifetch_buf_pkg.sv
// Shared types and sizing for the oc8051 instruction fetch buffer.
package oc8051_ifetch_buf_pkg;

  // Default geometry: 64 x 32-bit words, 4-word lines, 16 lines.
  localparam int IFB_ADR_WIDTH  = 6;
  localparam int IFB_LINE_WIDTH = 2;

  // Controller states: IDLE does lookups, FILL streams a line in from the bus.
  typedef enum logic {
    IFB_IDLE = 1'b0,
    IFB_FILL = 1'b1
  } ifb_state_e;

endpackage

// File: rtl/oc8051_ifb_ram.sv
// Data array of the fetch buffer: one write port, one synchronous read port.
// The read register is the CPU-facing instruction output and keeps its value
// until the next read.
module oc8051_ifb_ram #(
  parameter int ADR_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADR_WIDTH-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic                 re,
  input  logic [ADR_WIDTH-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADR_WIDTH];

  // Line fill writes, one word per bus acknowledge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read, only updated on a hit so the output holds between acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/oc8051_ifetch_buf.sv
// Direct-mapped, read-only instruction cache between the 8051 fetch port and
// the Wishbone instruction bus.
//
// Handshakes:
//   CPU side : a request is stb_i & cyc_i while ack_o is low; the CPU holds
//              stb_i and adr_i until the single-cycle ack_o pulse, and dat_o
//              is valid from that pulse until the next one.
//   Bus side : stb_o = cyc_o stays high for the whole line fill; a word is
//              accepted on a cycle with ack_i high and err_i low, otherwise
//              the same address is presented again (err_i means retry).
module oc8051_ifetch_buf
  import oc8051_ifetch_buf_pkg::*;
#(
  parameter int ADR_WIDTH  = IFB_ADR_WIDTH,
  parameter int LINE_WIDTH = IFB_LINE_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adr_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic        inv_i,
  output logic [15:0] adr_o,
  input  logic [31:0] dat_i,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic        ack_i,
  input  logic        err_i,
  output ifb_state_e  dbg_state
);

  localparam int IDX_WIDTH = ADR_WIDTH - LINE_WIDTH;
  localparam int BL_NUM    = (1 << IDX_WIDTH) - 1;
  localparam int TAG_WIDTH = 14 - ADR_WIDTH;
  localparam logic [LINE_WIDTH-1:0] CNT_ONE = 1;

  // Address split of the CPU request; byte offset bits are not used.
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [IDX_WIDTH-1:0]  req_index;
  logic [ADR_WIDTH-1:0]  req_word_adr;
  logic [1:0]            unused_byte_sel;

  assign req_tag         = adr_i[15:ADR_WIDTH+2];
  assign req_index       = adr_i[ADR_WIDTH+1:LINE_WIDTH+2];
  assign req_word_adr    = adr_i[ADR_WIDTH+1:2];
  assign unused_byte_sel = adr_i[1:0];

  // Controller and directory state.
  ifb_state_e            state;
  logic [TAG_WIDTH-1:0]  fill_tag;
  logic [IDX_WIDTH-1:0]  fill_index;
  logic [LINE_WIDTH-1:0] cnt;
  logic                  fill_inv;
  logic [BL_NUM:0]       valid;
  logic [TAG_WIDTH-1:0]  tag_arr [BL_NUM+1];

  logic req;
  logic hit;
  logic lookup_hit;
  logic lookup_miss;
  logic fill_ack;
  logic fill_last;

  // An invalidate in the same cycle as a lookup forces a miss so a stale
  // line is never returned.
  assign req         = stb_i & cyc_i & ~ack_o;
  assign hit         = valid[req_index] & (tag_arr[req_index] == req_tag);
  assign lookup_hit  = (state == IFB_IDLE) & req & hit & ~inv_i;
  assign lookup_miss = (state == IFB_IDLE) & req & ~(hit & ~inv_i);
  assign fill_ack    = (state == IFB_FILL) & ack_i & ~err_i;
  assign fill_last   = (cnt == '1);

  assign cyc_o     = stb_o;
  assign dbg_state = state;

  // Lookup/fill controller with registered bus and CPU handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IFB_IDLE;
      fill_tag   <= '0;
      fill_index <= '0;
      cnt        <= '0;
      fill_inv   <= 1'b0;
      valid      <= '0;
      adr_o      <= '0;
      stb_o      <= 1'b0;
      ack_o      <= 1'b0;
    end else begin
      ack_o <= lookup_hit;
      if (inv_i) valid <= '0;
      case (state)
        IFB_IDLE: begin
          if (lookup_miss) begin
            state      <= IFB_FILL;
            fill_tag   <= req_tag;
            fill_index <= req_index;
            cnt        <= '0;
            fill_inv   <= 1'b0;
            adr_o      <= {req_tag, req_index, {LINE_WIDTH{1'b0}}, 2'b00};
            stb_o      <= 1'b1;
          end
        end
        IFB_FILL: begin
          // An invalidate seen at any point of the fill keeps the line invalid.
          if (inv_i) fill_inv <= 1'b1;
          if (fill_ack) begin
            cnt   <= cnt + CNT_ONE;
            adr_o <= adr_o + 16'd4;
            if (fill_last) begin
              state <= IFB_IDLE;
              stb_o <= 1'b0;
              cnt   <= '0;
              if (!fill_inv && !inv_i) valid[fill_index] <= 1'b1;
            end
          end
        end
        default: state <= IFB_IDLE;
      endcase
    end
  end

  // Tag directory, written when the last word of a line arrives.
  always_ff @(posedge clk) begin
    if (fill_ack && fill_last) tag_arr[fill_index] <= fill_tag;
  end

  oc8051_ifb_ram #(
    .ADR_WIDTH(ADR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (fill_ack),
    .waddr ({fill_index, cnt}),
    .wdata (dat_i),
    .re    (lookup_hit),
    .raddr (req_word_adr),
    .rdata (dat_o)
  );

endmodule
